// File: rtl/seq_det_arb_pkg.sv
// seq_det_arb_pkg: shared types and constants for the seq_det_arb scheduler.
// Holds the FSM state enum, the default pattern and the count-width helper.
package seq_det_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SHIFT,
    REPORT
  } state_e;

  localparam int DEF_PAT_W = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

  // A frame of frame_w bits can hold at most frame_w hits, so the count
  // needs enough bits to represent frame_w itself.
  function automatic int calc_cnt_w(input int frame_w);
    return $clog2(frame_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_arb_if.sv
// seq_det_arb_if: request/frame bus between the frame producers (master)
// and the scheduler (slave), plus the result strobe going back.
interface seq_det_arb_if #(
  parameter int N_CH = 4,
  parameter int FRAME_W = 8
);
  import seq_det_arb_pkg::*;

  localparam int CH_W = $clog2(N_CH);
  localparam int CNT_W = calc_cnt_w(FRAME_W);

  logic [N_CH-1:0]         req;
  logic [N_CH*FRAME_W-1:0] frame;
  logic [N_CH-1:0]         gnt;
  logic                    busy;
  logic                    done;
  logic [CH_W-1:0]         done_ch;
  logic [CNT_W-1:0]        det_cnt;
  logic                    hit;

  modport master (
    output req, frame,
    input  gnt, busy, done, done_ch, det_cnt, hit
  );

  modport slave (
    input  req, frame,
    output gnt, busy, done, done_ch, det_cnt, hit
  );

endinterface

// File: rtl/seq_det_arb_serial_pat_det.sv
// serial_pat_det: serial pattern detector with overlapping matches.
// History, bits-seen qualifier and hit counter are all cleared by clr_i,
// so nothing carries over from one frame to the next.
module serial_pat_det
  import seq_det_arb_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             bit_i,
  input  logic             valid_i,
  output logic [CNT_W-1:0] cnt_o
);
  localparam int QW = $clog2(PAT_W);

  logic [PAT_W-2:0] hist_q;
  logic [QW-1:0]    seen_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PAT_W-1:0] window;
  logic             qualified;

  assign window    = {hist_q, bit_i};
  assign qualified = (seen_q == QW'(PAT_W - 1));
  assign cnt_o     = cnt_q;

  // Shift history, count bits up to PAT_W-1, and count qualified matches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      seen_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      hist_q <= '0;
      seen_q <= '0;
      cnt_q  <= '0;
    end else if (valid_i) begin
      hist_q <= window[PAT_W-2:0];
      if (!qualified) begin
        seen_q <= seen_q + QW'(1);
      end
      if (qualified && (window == PATTERN)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_det_arb.sv
// seq_det_arb: shares one serial pattern detector among N_CH requesters.
// Grants one frame at a time, shifts it MSB-first through the detector and
// reports the hit count with a one-cycle done strobe.
// Build option SEQ_DET_ARB_RR_EN: round-robin selection; when undefined the
// lowest requesting channel always wins.
module seq_det_arb
  import seq_det_arb_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int FRAME_W = 8,
  parameter int PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input logic          clock,
  input logic          reset,
  seq_det_arb_if.slave bus
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int CNT_W = calc_cnt_w(FRAME_W);
  localparam int SH_W  = $clog2(FRAME_W);

  state_e             state_q;
  logic [CH_W-1:0]    win_q;
  logic [CH_W-1:0]    win_d;
  logic [N_CH-1:0]    gnt_q;
  logic               busy_q;
  logic               done_q;
  logic [FRAME_W-1:0] sreg_q;
  logic [SH_W-1:0]    shCnt_q;
  logic [CNT_W-1:0]   detCnt;
  logic [FRAME_W-1:0] frameArr [N_CH];

`ifdef SEQ_DET_ARB_RR_EN
  logic [CH_W-1:0]    lastGnt_q;
  logic [CH_W-1:0]    rrIdx;
  int                 rrSum;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_frame
    assign frameArr[g] = bus.frame[g*FRAME_W +: FRAME_W];
  end

`ifdef SEQ_DET_ARB_RR_EN
  // Pick the first requester after the last granted one, wrapping around.
  always_comb begin
    win_d = '0;
    rrSum = 0;
    rrIdx = '0;
    for (int k = N_CH; k >= 1; k--) begin
      rrSum = int'(lastGnt_q) + k;
      if (rrSum >= N_CH) begin
        rrSum = rrSum - N_CH;
      end
      rrIdx = CH_W'(rrSum);
      if (bus.req[rrIdx]) begin
        win_d = rrIdx;
      end
    end
  end
`else
  // Pick the lowest-numbered requester.
  always_comb begin
    win_d = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        win_d = CH_W'(k);
      end
    end
  end
`endif

  // Arbiter FSM: grant, load and shift the frame, then strobe the result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      win_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sreg_q    <= '0;
      shCnt_q   <= '0;
`ifdef SEQ_DET_ARB_RR_EN
      lastGnt_q <= CH_W'(N_CH - 1);
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            state_q <= GRANT;
            win_q   <= win_d;
            gnt_q   <= N_CH'(1) << win_d;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          sreg_q    <= frameArr[win_q];
          shCnt_q   <= '0;
          state_q   <= SHIFT;
`ifdef SEQ_DET_ARB_RR_EN
          lastGnt_q <= win_q;
`endif
        end
        SHIFT: begin
          sreg_q <= sreg_q << 1;
          if (shCnt_q == SH_W'(FRAME_W - 1)) begin
            state_q <= REPORT;
            done_q  <= 1'b1;
          end else begin
            shCnt_q <= shCnt_q + SH_W'(1);
          end
        end
        REPORT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  serial_pat_det #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) u_det (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (state_q == GRANT),
    .bit_i   (sreg_q[FRAME_W-1]),
    .valid_i (state_q == SHIFT),
    .cnt_o   (detCnt)
  );

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_ch = win_q;
  assign bus.det_cnt = detCnt;
  assign bus.hit     = (detCnt != '0);

endmodule

// File: tb/tb_seq_det_arb.sv
// tb_seq_det_arb: randomized and directed bench for seq_det_arb with a
// behavioural model (window counting over the frame, arbitration by search).
module tb_seq_det_arb;
  import seq_det_arb_pkg::*;

  localparam int N_CH = 4;
  localparam int FRAME_W = 8;
  localparam int PAT_W = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1011;
  localparam int DONE_CYC = FRAME_W + 2;

  logic clock;
  logic reset;
  int checks = 0;
  int failures = 0;
  int modelLast = N_CH - 1;
  logic [FRAME_W-1:0] frames [N_CH];

  seq_det_arb_if #(.N_CH(N_CH), .FRAME_W(FRAME_W)) bus ();

  seq_det_arb #(
    .N_CH(N_CH), .FRAME_W(FRAME_W), .PAT_W(PAT_W), .PATTERN(PATTERN)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_frame(input int ch, input logic [FRAME_W-1:0] f);
    frames[ch] = f;
    bus.frame[ch*FRAME_W +: FRAME_W] = f;
  endtask

  // Count every PAT_W-wide window of the frame (MSB first) equal to PATTERN.
  function automatic int model_hits(input logic [FRAME_W-1:0] f);
    int n;
    logic [FRAME_W-1:0] s;
    n = 0;
    for (int p = 0; p + PAT_W <= FRAME_W; p++) begin
      s = f << p;
      if (s[FRAME_W-1 -: PAT_W] == PATTERN) n++;
    end
    return n;
  endfunction

  function automatic int model_winner(input logic [N_CH-1:0] r, input int last);
`ifdef SEQ_DET_ARB_RR_EN
    for (int k = 1; k <= N_CH; k++) begin
      if (r[(last + k) % N_CH]) return (last + k) % N_CH;
    end
`else
    for (int k = 0; k < N_CH; k++) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  function automatic logic [FRAME_W-1:0] rand_frame();
    logic [FRAME_W-1:0] f;
    int p;
    f = FRAME_W'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      p = int'($urandom_range(0, FRAME_W - PAT_W));
      f[FRAME_W-1-p -: PAT_W] = PATTERN;
    end
    return f;
  endfunction

  function automatic logic [N_CH-1:0] onehot(input int idx);
    logic [N_CH-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // Request with reqMask (already in IDLE), observe gnt at cycle 1, wait
  // (bounded) for done, then one more cycle to confirm the return to idle.
  task automatic do_transaction(input logic [N_CH-1:0] reqMask,
                                output logic [N_CH-1:0] gntSeen,
                                output int doneCycle, output int doneCh,
                                output int cnt, output logic hitV,
                                output logic protoOk,
                                output logic [N_CH-1:0] leftover);
    bit found;
    bus.req = reqMask;
    tick();
    gntSeen = bus.gnt;
    protoOk = (bus.busy === 1'b1) && (bus.done === 1'b0);
    leftover = reqMask & ~bus.gnt;
    bus.req = leftover;
    doneCycle = -1;
    doneCh = -1;
    cnt = -1;
    hitV = 1'b0;
    found = 1'b0;
    for (int c = 2; c <= 30 && !found; c++) begin
      tick();
      if (bus.gnt !== '0 || bus.busy !== 1'b1) protoOk = 1'b0;
      if (bus.done === 1'b1) begin
        found = 1'b1;
        doneCycle = c;
        doneCh = int'(bus.done_ch);
        cnt = int'(bus.det_cnt);
        hitV = bus.hit;
      end
    end
    if (found) begin
      tick();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.gnt !== '0) protoOk = 1'b0;
    end
    bus.req = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    modelLast = N_CH - 1;
    tick();
  endtask

  task automatic test_reset();
    logic idleOk;
    reset = 1'b0;
    bus.req = '0;
    bus.frame = '0;
    tick();
    tick();
    checks++; if (bus.gnt !== '0) begin failures++; $display("[TB] FAIL reset_gnt: got %b expected 0", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.done_ch !== '0) begin failures++; $display("[TB] FAIL reset_done_ch: got %0d expected 0", bus.done_ch); end
    checks++; if (bus.det_cnt !== '0) begin failures++; $display("[TB] FAIL reset_det_cnt: got %0d expected 0", bus.det_cnt); end
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("[TB] FAIL reset_hit: got %b expected 0", bus.hit); end
    reset = 1'b1;
    modelLast = N_CH - 1;
    idleOk = 1'b1;
    repeat (4) begin
      tick();
      if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) idleOk = 1'b0;
    end
    checks++; if (idleOk !== 1'b1) begin failures++; $display("[TB] FAIL idle_quiet: got %b expected 1", idleOk); end
  endtask

  task automatic test_single_request();
    logic [N_CH-1:0] g, lo;
    int dc, dch, cnt, expW, expCnt;
    logic hv, ok;
    set_frame(2, 8'b1011_0110);
    expW = model_winner(4'b0100, modelLast);
    expCnt = model_hits(frames[2]);
    do_transaction(4'b0100, g, dc, dch, cnt, hv, ok, lo);
    modelLast = expW;
    checks++; if (g !== onehot(expW)) begin failures++; $display("[TB] FAIL single_gnt: got %b expected %b", g, onehot(expW)); end
    checks++; if (dc !== DONE_CYC) begin failures++; $display("[TB] FAIL single_done_cycle: got %0d expected %0d", dc, DONE_CYC); end
    checks++; if (dch !== 2) begin failures++; $display("[TB] FAIL single_done_ch: got %0d expected 2", dch); end
    checks++; if (cnt !== expCnt) begin failures++; $display("[TB] FAIL single_det_cnt: got %0d expected %0d", cnt, expCnt); end
    checks++; if (hv !== 1'b1) begin failures++; $display("[TB] FAIL single_hit: got %b expected 1", hv); end
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_protocol: got %b expected 1", ok); end
  endtask

  task automatic test_overlap();
    logic [N_CH-1:0] g, lo;
    int dc, dch, cnt;
    logic hv, ok;
    set_frame(3, 8'b1011_1011);
    do_transaction(4'b1000, g, dc, dch, cnt, hv, ok, lo);
    modelLast = 3;
    checks++; if (cnt !== model_hits(frames[3])) begin failures++; $display("[TB] FAIL overlap_det_cnt: got %0d expected %0d", cnt, model_hits(frames[3])); end
    checks++; if (hv !== 1'b1) begin failures++; $display("[TB] FAIL overlap_hit: got %b expected 1", hv); end
    set_frame(1, 8'hFF);
    do_transaction(4'b0010, g, dc, dch, cnt, hv, ok, lo);
    modelLast = 1;
    checks++; if (cnt !== 0) begin failures++; $display("[TB] FAIL ones_det_cnt: got %0d expected 0", cnt); end
    checks++; if (hv !== 1'b0) begin failures++; $display("[TB] FAIL ones_hit: got %b expected 0", hv); end
  endtask

  task automatic test_no_cross_history();
    logic [N_CH-1:0] g, lo;
    int dc, dch, cnt;
    logic hv, ok;
    set_frame(0, 8'b0000_0101);
    set_frame(1, 8'b1000_0000);
    do_transaction(4'b0001, g, dc, dch, cnt, hv, ok, lo);
    modelLast = 0;
    checks++; if (cnt !== 0) begin failures++; $display("[TB] FAIL xframe_first_cnt: got %0d expected 0", cnt); end
    do_transaction(4'b0010, g, dc, dch, cnt, hv, ok, lo);
    modelLast = 1;
    checks++; if (cnt !== 0) begin failures++; $display("[TB] FAIL xframe_second_cnt: got %0d expected 0", cnt); end
    checks++; if (dch !== 1) begin failures++; $display("[TB] FAIL xframe_done_ch: got %0d expected 1", dch); end
  endtask

  // All channels request continuously; the order comes straight from the
  // arbitration rule starting after a reset.
  task automatic test_back_to_back();
    logic [N_CH-1:0] g, lo;
    int dc, dch, cnt;
    logic hv, ok;
    int expOrder [5];
`ifdef SEQ_DET_ARB_RR_EN
    expOrder = '{0, 1, 2, 3, 0};
`else
    expOrder = '{0, 0, 0, 0, 0};
`endif
    pulse_reset();
    for (int ch = 0; ch < N_CH; ch++) set_frame(ch, rand_frame());
    for (int i = 0; i < 5; i++) begin
      do_transaction(4'b1111, g, dc, dch, cnt, hv, ok, lo);
      modelLast = expOrder[i];
      checks++; if (g !== onehot(expOrder[i])) begin failures++; $display("[TB] FAIL b2b_gnt[%0d]: got %b expected %b", i, g, onehot(expOrder[i])); end
      checks++; if (!$onehot(g)) begin failures++; $display("[TB] FAIL b2b_onehot[%0d]: got %b expected one-hot", i, g); end
      checks++; if (cnt !== model_hits(frames[expOrder[i]])) begin failures++; $display("[TB] FAIL b2b_det_cnt[%0d]: got %0d expected %0d", i, cnt, model_hits(frames[expOrder[i]])); end
      checks++; if (dc !== DONE_CYC || ok !== 1'b1) begin failures++; $display("[TB] FAIL b2b_timing[%0d]: got done cycle %0d ok %b expected %0d ok 1", i, dc, ok, DONE_CYC); end
    end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] g, lo, pending;
    int dc, dch, cnt, expW, expCnt;
    logic hv, ok;
    pending = '0;
    for (int it = 0; it < 24; it++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (!pending[ch]) set_frame(ch, rand_frame());
      end
      pending = pending | N_CH'($urandom_range(0, (1 << N_CH) - 1));
      if (pending == '0) pending = onehot(int'($urandom_range(0, N_CH - 1)));
      expW = model_winner(pending, modelLast);
      expCnt = model_hits(frames[expW]);
      do_transaction(pending, g, dc, dch, cnt, hv, ok, lo);
      modelLast = expW;
      checks++; if (g !== onehot(expW)) begin failures++; $display("[TB] FAIL rand_gnt[%0d]: got %b expected %b (req %b)", it, g, onehot(expW), pending); end
      checks++; if (dch !== expW) begin failures++; $display("[TB] FAIL rand_done_ch[%0d]: got %0d expected %0d", it, dch, expW); end
      checks++; if (cnt !== expCnt) begin failures++; $display("[TB] FAIL rand_det_cnt[%0d]: got %0d expected %0d (frame %b)", it, cnt, expCnt, frames[expW]); end
      checks++; if (hv !== (expCnt != 0)) begin failures++; $display("[TB] FAIL rand_hit[%0d]: got %b expected %b", it, hv, (expCnt != 0)); end
      checks++; if (dc !== DONE_CYC || ok !== 1'b1) begin failures++; $display("[TB] FAIL rand_timing[%0d]: got done cycle %0d ok %b expected %0d ok 1", it, dc, ok, DONE_CYC); end
      pending = lo;
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [N_CH-1:0] g, lo;
    int dc, dch, cnt;
    logic hv, ok, sawDone;
    set_frame(2, 8'b1011_0110);
    bus.req = 4'b0100;
    tick();
    bus.req = '0;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.gnt !== '0) begin failures++; $display("[TB] FAIL midreset_gnt: got %b expected 0", bus.gnt); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL midreset_done: got %b expected 0", bus.done); end
    checks++; if (bus.det_cnt !== '0) begin failures++; $display("[TB] FAIL midreset_det_cnt: got %0d expected 0", bus.det_cnt); end
    tick();
    tick();
    reset = 1'b1;
    modelLast = N_CH - 1;
    sawDone = 1'b0;
    repeat (12) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone = 1'b1;
    end
    checks++; if (sawDone !== 1'b0) begin failures++; $display("[TB] FAIL midreset_no_done: got %b expected 0", sawDone); end
    set_frame(1, rand_frame());
    set_frame(3, rand_frame());
    do_transaction(4'b1010, g, dc, dch, cnt, hv, ok, lo);
    modelLast = 1;
    checks++; if (g !== 4'b0010) begin failures++; $display("[TB] FAIL postreset_gnt: got %b expected 0010", g); end
    checks++; if (dch !== 1 || cnt !== model_hits(frames[1])) begin failures++; $display("[TB] FAIL postreset_result: got ch %0d cnt %0d expected ch 1 cnt %0d", dch, cnt, model_hits(frames[1])); end
    do_transaction(lo, g, dc, dch, cnt, hv, ok, lo);
    modelLast = 3;
    checks++; if (g !== 4'b1000) begin failures++; $display("[TB] FAIL postreset_drain_gnt: got %b expected 1000", g); end
  endtask

  initial begin
    reset = 1'b0;
    bus.req = '0;
    bus.frame = '0;
    for (int ch = 0; ch < N_CH; ch++) frames[ch] = '0;
    test_reset();
    test_single_request();
    test_overlap();
    test_no_cross_history();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seq_det_arb.md
# seq_det_arb

Round-robin scheduler that shares one serial pattern detector among `N_CH` requesters. Each requester presents a parallel `FRAME_W`-bit frame. The block grants one requester at a time, serialises the granted frame MSB-first into the detector, and counts overlapping pattern hits within that frame. It reports the count and channel on a one-cycle `done` pulse. It sits between the frame producers and the detector datapath.

## Interface
- `N_CH`, default 4: number of requesters (≥2).
- `FRAME_W`, default 8: frame length in bits (≥ `PAT_W`).
- `PAT_W`, default 4: pattern length.
- `PATTERN`, default 4'b1011: pattern to detect, MSB is the first bit received.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  `N_CH`  per-channel request; held until that channel's `gnt`.
- `frame`  in  `N_CH*FRAME_W`  channel i frame in bits `[i*FRAME_W +: FRAME_W]`; stable while `req[i]`=1.
- `gnt`  out  `N_CH`  one-hot, one-cycle accept pulse.
- `busy`  out  1  high from the `gnt` cycle through the `done` cycle.
- `done`  out  1  one-cycle result strobe.
- `done_ch`  out  `$clog2(N_CH)`  channel of the reported frame; valid with `done`.
- `det_cnt`  out  `CNT_W`=`$clog2(FRAME_W+1)`  hits in the frame; valid with `done`.
- `hit`  out  1  `det_cnt`≠0; valid with `done`.

## Operation
- FSM states: `IDLE` → `GRANT` → `SHIFT` → `REPORT` → `IDLE`.
- **IDLE:** if `req`≠0, select the winner and go to `GRANT`. Otherwise stay.
- **Round-robin selection:** search starts at `last_gnt+1` mod `N_CH`. `last_gnt` resets to `N_CH-1`, so ch0 wins first after reset.
- **GRANT:**
  - `gnt[win]`=1 for exactly one cycle.
  - The winner's frame is latched into the shift register on the closing edge.
  - `last_gnt` is updated to `win`.
  - Detector history and hit counter are cleared.
- **SHIFT:** exactly `FRAME_W` cycles, one bit per cycle, MSB first.
  - The detector compares `{hist[PAT_W-2:0], bit}` against `PATTERN`.
  - A hit counts only once at least `PAT_W` bits of this frame have been shifted.
  - Detection overlaps within a frame; there is no history across frames.
- **REPORT:** `done`=1, and `done_ch`/`det_cnt`/`hit` are driven, for one cycle, then go to `IDLE`.
- `req` is ignored outside `IDLE`.
- A requester must drop `req` the cycle after its `gnt`. A `req` still high in the next `IDLE` is treated as a new request.
- **Count arithmetic:** unsigned; maximum `FRAME_W-PAT_W+1`, so it never saturates or wraps.
- **Reset values:** `gnt`=0, `busy`=0, `done`=0, `done_ch`=0, `det_cnt`=0, `hit`=0, state `IDLE`, shift register 0.
- **Reset mid-operation:** asserting `reset` in any state clears all outputs immediately. The in-flight frame is discarded and no `done` is issued.

## Timing
- Cycle 0: `req` sampled in `IDLE`.
- Cycle 1: `gnt`.
- Cycles 2 … `FRAME_W+1`: `SHIFT`.
- Cycle `FRAME_W+2`: `done` (cycle 10 for defaults).
- Back-to-back frames: one frame per `FRAME_W+3` cycles; the next `gnt` comes no earlier than 2 cycles after `done`.
- Outputs are registered; there are no combinational paths from `req`/`frame` to outputs.

## Configuration
- `SEQ_DET_ARB_RR_EN` defined: round-robin selection as described above.
- `SEQ_DET_ARB_RR_EN` undefined: fixed priority, where the lowest requesting index always wins. `last_gnt` logic is removed; all other behaviour and timing are identical.

## Structure
- **Shared package `seq_det_arb_pkg`:**
  - FSM state enum (`IDLE`, `GRANT`, `SHIFT`, `REPORT`).
  - Default `PATTERN`/`PAT_W` constants.
  - The `CNT_W` function.
- **Sub-module `serial_pat_det`:** holds history register, bit-count qualifier and hit counter. It has a `clr` input and `bit`/`valid` inputs, and outputs `cnt`. The arbiter FSM, round-robin pointer and shift register stay in `seq_det_arb`.

## Test plan
All scenarios use defaults (`N_CH`=4, `FRAME_W`=8, `PATTERN`=1011); "cycle" counts from `req` rising.
- **Single request:** `req`=0100, frame2=8'b1011_0110 → `gnt`=0100 at cycle 1; `done` at cycle 10 with `done_ch`=2, `det_cnt`=2, `hit`=1.
- **Overlapping hits:** frame 8'b1011_1011 → `det_cnt`=2. Frame 8'hFF → `det_cnt`=0, `hit`=0.
- **No cross-frame history:** ch0 frame 8'b0000_0101 followed by ch1 frame 8'b1000_0000 → both report `det_cnt`=0.
- **All channels requesting:** `req`=1111 re-asserted after each `gnt` →
  - with `SEQ_DET_ARB_RR_EN`: grant order 0,1,2,3,0;
  - without it: 0,0,0,0.
  - `gnt` is always one-hot.
- **Reset during SHIFT:** `reset` low at cycle 5 → `busy`/`gnt`/`done`/`det_cnt` are 0 in the same cycle, and no `done` follows. After release with `req`=1010 → `gnt`=0010 (ch1 wins; the round-robin pointer was reset).
